power_event_sequencer: RTL and testbench
========================================

POWER_EVENT_SEQUENCER -- requirements
Module: power_event_sequencer

Interface
REQ-001 SHALL have parameter PWROK_TIMEOUT_S, default 4: Strobe1s ticks allowed for PWRGD_PS_PWROK_3V3 to rise after FM_PS_EN assertion.
REQ-002 SHALL have parameter SIO_PULSE_TICKS, default 2: width of the synthetic SIO power-button pulse, in Strobe125ms ticks.
REQ-003 SHALL have parameter FORCE_OFF_S, default 4: Strobe1s ticks of continuous button hold that force power off.
REQ-004 Port MainReset  in  1  reset, asynchronous, active-low.
REQ-005 Port SlowClock  in  1  32,768 Hz clock; all flops on posedge.
REQ-006 Port Strobe1s  in  1  single-SlowClock pulse every 1 s.
REQ-007 Port Strobe125ms  in  1  single-SlowClock pulse every 125 ms.
REQ-008 Port PowerButtonDebounce  in  1  debounced power button; 0 = pressed.
REQ-009 Port PowerRelease  in  1  single-cycle pulse on button release.
REQ-010 Port PWRGD_PS_PWROK_3V3  in  1  3V3 power good; 1 = good.
REQ-011 Port SlpS3_N  in  1  chipset S3 sleep; 0 = host requests off.
REQ-012 Port FM_PS_EN  out  1  power-supply enable; 1 = on.
REQ-013 Port PowerbuttonEvt  out  1  SIO button gate; 0 = synthetic press.
REQ-014 Port PowerEvtState  out  4  current FSM state code.
REQ-015 Port PowerFault  out  1  1 while in FAULT.

Function
REQ-016 FSM codes SHALL be: STANDBY 4'h0, PS_ON 4'h1, SIO_PULSE 4'h2, RUNNING 4'h3, FORCE_OFF 4'h4, FAULT 4'h5; PowerEvtState SHALL equal the registered state; codes 6-F SHALL return to STANDBY next cycle.
REQ-017 All outputs SHALL be registered; decode from state, no combinational input-to-output path.
REQ-018 FM_PS_EN SHALL be 1 in PS_ON, SIO_PULSE, RUNNING; 0 otherwise.
REQ-019 PowerbuttonEvt SHALL be 0 only in SIO_PULSE; PowerFault 1 only in FAULT.
REQ-020 STANDBY: PowerRelease=1 -> PS_ON.
REQ-021 PS_ON: PWRGD=1 -> SIO_PULSE (priority); else counter increments per Strobe1s; counter reaching PWROK_TIMEOUT_S -> FAULT.
REQ-022 SIO_PULSE: counter increments per Strobe125ms; reaching SIO_PULSE_TICKS -> RUNNING; PWRGD=0 -> FAULT (priority).
REQ-023 RUNNING priority: PWRGD=0 -> FAULT; else SlpS3_N=0 -> STANDBY; else hold counter reaching FORCE_OFF_S -> FORCE_OFF.
REQ-024 RUNNING hold counter: increments on Strobe1s while PowerButtonDebounce=0; clears on any cycle with PowerButtonDebounce=1; saturates.
REQ-025 FORCE_OFF: PowerButtonDebounce=1 -> STANDBY; PowerRelease pulses in FORCE_OFF SHALL be ignored (no re-power).
REQ-026 FAULT: PowerRelease=1 -> STANDBY; other inputs ignored.
REQ-027 One shared 4-bit counter SHALL clear on every state transition; timeouts count whole strobes, so accuracy is -1 strobe period/+0.
REQ-028 Strobe1s and Strobe125ms coinciding SHALL each be honoured per the current state only.
REQ-029 Transition latency: one SlowClock after qualifying input sample.

Reset
REQ-030 MainReset=0 SHALL force state STANDBY, counter 0, FM_PS_EN=0, PowerbuttonEvt=1, PowerEvtState=4'h0, PowerFault=0, immediately and mid-operation.
REQ-031 Reset release SHALL resume in STANDBY on the next SlowClock edge with no glitch on FM_PS_EN.

Configuration
REQ-032 Macro PSEQ_AUTO_POWERON_EN defined: one flop set by reset SHALL move STANDBY -> PS_ON on the first cycle after MainReset release, then clear; later entries to STANDBY wait for PowerRelease.
REQ-033 Macro undefined: the flop SHALL not exist; STANDBY leaves only on PowerRelease.

Verification
REQ-034 Power-on: PowerRelease pulse, PWRGD=1 after 300 ms -> FM_PS_EN=1 next cycle, state 1->2, PowerbuttonEvt=0 for 2 Strobe125ms ticks, state 3.
REQ-035 Timeout: PowerRelease, PWRGD held 0 -> FAULT (4'h5) at 4th Strobe1s, FM_PS_EN=0, PowerFault=1; PowerRelease -> state 0.
REQ-036 Force-off: in RUNNING hold button 4 Strobe1s -> state 4, FM_PS_EN=0; release -> state 0; 3 s hold, release, re-hold 3 s -> stays RUNNING.
REQ-037 Priority: in RUNNING, PWRGD=0 and SlpS3_N=0 same cycle -> FAULT, not STANDBY.
REQ-038 Reset: MainReset=0 during SIO_PULSE -> PowerbuttonEvt=1, FM_PS_EN=0, state 0 asynchronously.
REQ-039 Macro: with PSEQ_AUTO_POWERON_EN, release reset -> state 1 after one cycle without PowerRelease; without it, state stays 0 for 10 s.

Source files
------------

// File: rtl/power_event_sequencer.sv
// Power-event sequencer: button-driven PSU enable, SIO pulse, force-off and PWROK fault handling.
// Optional macro PSEQ_AUTO_POWERON_EN: leave STANDBY automatically once after reset release.
module power_event_sequencer #(
   parameter int unsigned PWROK_TIMEOUT_S = 4,
   parameter int unsigned SIO_PULSE_TICKS = 2,
   parameter int unsigned FORCE_OFF_S     = 4
) (
   input  logic       MainReset,
   input  logic       SlowClock,
   input  logic       Strobe1s,
   input  logic       Strobe125ms,
   input  logic       PowerButtonDebounce,
   input  logic       PowerRelease,
   input  logic       PWRGD_PS_PWROK_3V3,
   input  logic       SlpS3_N,
   output logic       FM_PS_EN,
   output logic       PowerbuttonEvt,
   output logic [3:0] PowerEvtState,
   output logic       PowerFault
);

   typedef enum logic [3:0] {
      Standby  = 4'h0,
      PsOn     = 4'h1,
      SioPulse = 4'h2,
      Running  = 4'h3,
      ForceOff = 4'h4,
      Fault    = 4'h5
   } stateT;

   stateT       state, nextState;
   logic [3:0]  counter, nextCounter;
   logic [31:0] countPlusOne;
   logic        startRequest;

   assign countPlusOne = 32'(counter) + 32'd1;

`ifdef PSEQ_AUTO_POWERON_EN
   logic autoPowerOn;

   // Set while reset is held, consumed on the first clock after release.
   always_ff @(posedge SlowClock or negedge MainReset) begin
      if (!MainReset) begin
         autoPowerOn <= 1'b1;
      end else begin
         autoPowerOn <= 1'b0;
      end
   end

   assign startRequest = PowerRelease | autoPowerOn;
`else
   assign startRequest = PowerRelease;
`endif

   always_comb begin
      nextState   = state;
      nextCounter = counter;
      case (state)
         Standby: begin
            if (startRequest) nextState = PsOn;
         end
         PsOn: begin
            if (PWRGD_PS_PWROK_3V3) begin
               nextState = SioPulse;
            end else if (Strobe1s) begin
               if (countPlusOne >= PWROK_TIMEOUT_S) nextState = Fault;
               else nextCounter = counter + 4'd1;
            end
         end
         SioPulse: begin
            if (!PWRGD_PS_PWROK_3V3) begin
               nextState = Fault;
            end else if (Strobe125ms) begin
               if (countPlusOne >= SIO_PULSE_TICKS) nextState = Running;
               else nextCounter = counter + 4'd1;
            end
         end
         Running: begin
            if (!PWRGD_PS_PWROK_3V3) begin
               nextState = Fault;
            end else if (!SlpS3_N) begin
               nextState = Standby;
            end else if (PowerButtonDebounce) begin
               nextCounter = 4'd0;
            end else if (Strobe1s) begin
               if (countPlusOne >= FORCE_OFF_S) nextState = ForceOff;
               else if (counter != 4'hF) nextCounter = counter + 4'd1;
            end
         end
         ForceOff: begin
            // A release pulse while still held must not re-power the platform.
            if (PowerButtonDebounce) nextState = Standby;
         end
         Fault: begin
            if (PowerRelease) nextState = Standby;
         end
         default: nextState = Standby;
      endcase
      if (nextState != state) nextCounter = 4'd0;
   end

   // Outputs are decoded from the next state so they change in the same edge as the state.
   always_ff @(posedge SlowClock or negedge MainReset) begin
      if (!MainReset) begin
         state          <= Standby;
         counter        <= 4'd0;
         FM_PS_EN       <= 1'b0;
         PowerbuttonEvt <= 1'b1;
         PowerFault     <= 1'b0;
      end else begin
         state          <= nextState;
         counter        <= nextCounter;
         FM_PS_EN       <= (nextState == PsOn) || (nextState == SioPulse) ||
                           (nextState == Running);
         PowerbuttonEvt <= (nextState != SioPulse);
         PowerFault     <= (nextState == Fault);
      end
   end

   assign PowerEvtState = state;

endmodule

// File: tb/tb_power_event_sequencer.sv
// Self-checking bench for power_event_sequencer: directed scenarios plus randomized run
// against a rule-level reference model. Strobes are time-scaled (125 ms = 4 clocks, 1 s = 32).
module tb_power_event_sequencer;

   localparam int PwrokS   = 4;
   localparam int SioTicks = 2;
   localparam int ForceS   = 4;

   logic       MainReset = 1'b0;
   logic       SlowClock = 1'b0;
   logic       Strobe1s = 1'b0;
   logic       Strobe125ms = 1'b0;
   logic       PowerButtonDebounce = 1'b1;
   logic       PowerRelease = 1'b0;
   logic       PWRGD_PS_PWROK_3V3 = 1'b0;
   logic       SlpS3_N = 1'b1;
   logic       FM_PS_EN;
   logic       PowerbuttonEvt;
   logic [3:0] PowerEvtState;
   logic       PowerFault;

   int passCnt = 0;
   int totalCnt = 0;
   int cyc = 0;

   // Reference model: state code plus per-phase elapsed-strobe counts.
   int mState = 0;
   int mSec = 0;
   int mTick = 0;
   int mHold = 0;
   bit mAuto = 1'b0;

   power_event_sequencer #(
      .PWROK_TIMEOUT_S(PwrokS),
      .SIO_PULSE_TICKS(SioTicks),
      .FORCE_OFF_S    (ForceS)
   ) dut (
      .MainReset          (MainReset),
      .SlowClock          (SlowClock),
      .Strobe1s           (Strobe1s),
      .Strobe125ms        (Strobe125ms),
      .PowerButtonDebounce(PowerButtonDebounce),
      .PowerRelease       (PowerRelease),
      .PWRGD_PS_PWROK_3V3 (PWRGD_PS_PWROK_3V3),
      .SlpS3_N            (SlpS3_N),
      .FM_PS_EN           (FM_PS_EN),
      .PowerbuttonEvt     (PowerbuttonEvt),
      .PowerEvtState      (PowerEvtState),
      .PowerFault         (PowerFault)
   );

   always #5 SlowClock = ~SlowClock;

   function automatic bit is1s(input int c);
      return (c % 32) == 31;
   endfunction

   function automatic bit is125(input int c);
      return (c % 4) == 3;
   endfunction

   task automatic modelReset();
      mState = 0;
      mSec = 0;
      mTick = 0;
      mHold = 0;
`ifdef PSEQ_AUTO_POWERON_EN
      mAuto = 1'b1;
`else
      mAuto = 1'b0;
`endif
   endtask

   task automatic modelAdvance(input bit btn, input bit rel, input bit pg, input bit slp,
                               input bit s1, input bit s125);
      int nxt;
      nxt = mState;
      case (mState)
         0: if (rel || mAuto) nxt = 1;
         1: begin
            if (pg) nxt = 2;
            else if (s1) begin
               mSec++;
               if (mSec >= PwrokS) nxt = 5;
            end
         end
         2: begin
            if (!pg) nxt = 5;
            else if (s125) begin
               mTick++;
               if (mTick >= SioTicks) nxt = 3;
            end
         end
         3: begin
            if (!pg) nxt = 5;
            else if (!slp) nxt = 0;
            else if (btn) mHold = 0;
            else if (s1) begin
               if (mHold < 15) mHold++;
               if (mHold >= ForceS) nxt = 4;
            end
         end
         4: if (btn) nxt = 0;
         5: if (rel) nxt = 0;
         default: nxt = 0;
      endcase
      mAuto = 1'b0;
      if (nxt != mState) begin
         mSec = 0;
         mTick = 0;
         mHold = 0;
      end
      mState = nxt;
   endtask

   // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
   task automatic step(input bit btn, input bit rel, input bit pg, input bit slp);
      bit s1, s125;
      s1 = is1s(cyc);
      s125 = is125(cyc);
      PowerButtonDebounce = btn;
      PowerRelease = rel;
      PWRGD_PS_PWROK_3V3 = pg;
      SlpS3_N = slp;
      Strobe1s = s1;
      Strobe125ms = s125;
      modelAdvance(btn, rel, pg, slp, s1, s125);
      @(posedge SlowClock);
      #1;
      cyc++;
   endtask

   task automatic doReset();
      #2;
      MainReset = 1'b0;
      modelReset();
      #2;
      MainReset = 1'b1;
   endtask

   task automatic goStandby();
      int n;
      n = 0;
      while (mState != 0 && n < 100) begin
         case (mState)
            1, 2: step(1, 0, 1, 1);
            3: step(1, 0, 1, 0);
            4: step(1, 0, 1, 1);
            default: step(1, 1, 0, 1);
         endcase
         n++;
      end
      totalCnt++;
      if (PowerEvtState !== 4'h0) $display("FAIL goStandby: state %0h expected 0", PowerEvtState);
      else passCnt++;
   endtask

   task automatic powerToRunning();
      int n;
      step(1, 1, 0, 1);
      n = 0;
      while (mState != 3 && n < 50) begin
         step(1, 0, 1, 1);
         n++;
      end
      totalCnt++;
      if (PowerEvtState !== 4'h3) $display("FAIL powerToRunning: state %0h expected 3", PowerEvtState);
      else passCnt++;
   endtask

   task automatic test_reset();
      #12;
      totalCnt++;
      if ({PowerEvtState, FM_PS_EN, PowerbuttonEvt, PowerFault} !== 7'b0000_010)
         $display("FAIL reset_outputs: got state %0h en %b evt %b fault %b expected 0 0 1 0",
                  PowerEvtState, FM_PS_EN, PowerbuttonEvt, PowerFault);
      else passCnt++;
      @(posedge SlowClock);
      #1;
      MainReset = 1'b1;
      modelReset();
      step(1, 0, 0, 1);
`ifdef PSEQ_AUTO_POWERON_EN
      totalCnt++;
      if (PowerEvtState !== 4'h1) $display("FAIL auto_poweron: state %0h expected 1", PowerEvtState);
      else passCnt++;
`else
      for (int i = 0; i < 320; i++) step(1, 0, 0, 1);
      totalCnt++;
      if (PowerEvtState !== 4'h0) $display("FAIL standby_10s: state %0h expected 0", PowerEvtState);
      else passCnt++;
`endif
      goStandby();
   endtask

   task automatic test_power_on();
      int n, ticks;
      step(1, 1, 0, 1);
      totalCnt++;
      if (PowerEvtState !== 4'h1 || FM_PS_EN !== 1'b1)
         $display("FAIL ps_on_entry: state %0h en %b expected 1 1", PowerEvtState, FM_PS_EN);
      else passCnt++;
      for (int i = 0; i < 10; i++) step(1, 0, 0, 1);
      step(1, 0, 1, 1);
      totalCnt++;
      if (PowerEvtState !== 4'h2 || PowerbuttonEvt !== 1'b0 || FM_PS_EN !== 1'b1)
         $display("FAIL sio_entry: state %0h evt %b en %b expected 2 0 1",
                  PowerEvtState, PowerbuttonEvt, FM_PS_EN);
      else passCnt++;
      n = 0;
      ticks = 0;
      while (PowerEvtState == 4'h2 && n < 40) begin
         if (is125(cyc)) ticks++;
         step(1, 0, 1, 1);
         n++;
      end
      totalCnt++;
      if (PowerEvtState !== 4'h3 || PowerbuttonEvt !== 1'b1)
         $display("FAIL running_entry: state %0h evt %b expected 3 1", PowerEvtState, PowerbuttonEvt);
      else passCnt++;
      totalCnt++;
      if (ticks !== SioTicks) $display("FAIL sio_width: ticks %0d expected %0d", ticks, SioTicks);
      else passCnt++;
   endtask

   task automatic test_timeout();
      int n, secs;
      goStandby();
      step(1, 1, 0, 1);
      n = 0;
      secs = 0;
      while (PowerEvtState == 4'h1 && n < 200) begin
         if (is1s(cyc)) secs++;
         step(1, 0, 0, 1);
         n++;
      end
      totalCnt++;
      if (PowerEvtState !== 4'h5 || FM_PS_EN !== 1'b0 || PowerFault !== 1'b1)
         $display("FAIL timeout_fault: state %0h en %b fault %b expected 5 0 1",
                  PowerEvtState, FM_PS_EN, PowerFault);
      else passCnt++;
      totalCnt++;
      if (secs !== PwrokS) $display("FAIL timeout_secs: got %0d expected %0d", secs, PwrokS);
      else passCnt++;
      step(0, 0, 1, 0);
      totalCnt++;
      if (PowerEvtState !== 4'h5) $display("FAIL fault_hold: state %0h expected 5", PowerEvtState);
      else passCnt++;
      step(1, 1, 0, 1);
      totalCnt++;
      if (PowerEvtState !== 4'h0 || PowerFault !== 1'b0)
         $display("FAIL fault_exit: state %0h fault %b expected 0 0", PowerEvtState, PowerFault);
      else passCnt++;
   endtask

   task automatic test_force_off();
      int n, secs;
      powerToRunning();
      n = 0;
      secs = 0;
      while (PowerEvtState == 4'h3 && n < 200) begin
         if (is1s(cyc)) secs++;
         step(0, 0, 1, 1);
         n++;
      end
      totalCnt++;
      if (PowerEvtState !== 4'h4 || FM_PS_EN !== 1'b0)
         $display("FAIL force_off: state %0h en %b expected 4 0", PowerEvtState, FM_PS_EN);
      else passCnt++;
      totalCnt++;
      if (secs !== ForceS) $display("FAIL force_secs: got %0d expected %0d", secs, ForceS);
      else passCnt++;
      step(0, 1, 1, 1);
      totalCnt++;
      if (PowerEvtState !== 4'h4) $display("FAIL force_release_ignored: state %0h expected 4", PowerEvtState);
      else passCnt++;
      step(1, 0, 1, 1);
      totalCnt++;
      if (PowerEvtState !== 4'h0) $display("FAIL force_exit: state %0h expected 0", PowerEvtState);
      else passCnt++;
      powerToRunning();
      for (int k = 0; k < 2; k++) begin
         secs = 0;
         while (secs < ForceS - 1) begin
            if (is1s(cyc)) secs++;
            step(0, 0, 1, 1);
         end
         step(1, 0, 1, 1);
      end
      totalCnt++;
      if (PowerEvtState !== 4'h3 || FM_PS_EN !== 1'b1)
         $display("FAIL hold_clear: state %0h en %b expected 3 1", PowerEvtState, FM_PS_EN);
      else passCnt++;
   endtask

   task automatic test_priority();
      step(1, 0, 0, 0);
      totalCnt++;
      if (PowerEvtState !== 4'h5 || PowerFault !== 1'b1)
         $display("FAIL priority: state %0h fault %b expected 5 1", PowerEvtState, PowerFault);
      else passCnt++;
      goStandby();
   endtask

   task automatic test_reset_mid();
      step(1, 1, 0, 1);
      step(1, 0, 1, 1);
      totalCnt++;
      if (PowerEvtState !== 4'h2 || PowerbuttonEvt !== 1'b0)
         $display("FAIL mid_sio: state %0h evt %b expected 2 0", PowerEvtState, PowerbuttonEvt);
      else passCnt++;
      #2;
      MainReset = 1'b0;
      modelReset();
      #1;
      totalCnt++;
      if ({PowerEvtState, FM_PS_EN, PowerbuttonEvt, PowerFault} !== 7'b0000_010)
         $display("FAIL async_reset: got state %0h en %b evt %b fault %b expected 0 0 1 0",
                  PowerEvtState, FM_PS_EN, PowerbuttonEvt, PowerFault);
      else passCnt++;
      MainReset = 1'b1;
      goStandby();
   endtask

   task automatic test_random();
      bit btn, pg, slp, rel;
      btn = 1'b1;
      pg = 1'b0;
      slp = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         rel = ($urandom % 12) == 0;
         if (($urandom % 40) == 0) btn = ~btn;
         if (($urandom % 50) == 0) pg = ~pg;
         if (($urandom % 70) == 0) slp = ~slp;
         step(btn, rel, pg, slp);
         totalCnt++;
         if ({PowerEvtState, FM_PS_EN, PowerbuttonEvt, PowerFault} !==
             {4'(mState), (mState >= 1 && mState <= 3), (mState != 2), (mState == 5)})
            $display("FAIL random cyc %0d: got state %0h en %b evt %b fault %b model state %0d",
                     cyc, PowerEvtState, FM_PS_EN, PowerbuttonEvt, PowerFault, mState);
         else passCnt++;
      end
   endtask

   initial begin
      test_reset();
      test_power_on();
      test_timeout();
      test_force_off();
      test_priority();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
